// File: rtl/regfile_mp.sv
// Multi-port register file with x0 hardwired to zero, a pending-write scoreboard,
// optional same-cycle write forwarding and a one-register-per-cycle clear after reset.
module regfile_mp #(
   parameter  int XLEN   = 32,
   parameter  int NREGS  = 32,
   parameter  int NRD    = 2,
   parameter  int BYPASS = 1,
   localparam int AW     = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NRD*AW-1:0]   rs,
   output logic [NRD*XLEN-1:0] data,
   output logic [NRD-1:0]      rs_busy,
   input  logic [AW-1:0]       rd,
   input  logic [XLEN-1:0]     rd_data,
   input  logic                reg_write,
   input  logic                sb_set,
   input  logic [AW-1:0]       sb_rd,
   output logic                ready
);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [AW-1:0]     clr_idx;
   logic [XLEN-1:0]   regs [NREGS];
   logic [NREGS-1:0]  busy;
   logic              clr_en;
   logic              wr_en;
   logic              set_en;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= CLEAR;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR:   if (clr_idx == AW'(NREGS - 1)) state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = CLEAR;
      endcase
   end

   // Output / enable decode; reset forces every output low combinationally
   always_comb begin
      ready  = rst_n && (state == RUN);
      clr_en = rst_n && (state == CLEAR);
      wr_en  = ready && reg_write && (rd != '0);
      set_en = ready && sb_set && (sb_rd != '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)      clr_idx <= '0;
      else if (clr_en) clr_idx <= clr_idx + 1'b1;
   end

   // Storage carries no reset: the clear sequence zeroes it before it becomes visible
   always_ff @(posedge clk) begin
      if (clr_en)     regs[clr_idx] <= '0;
      else if (wr_en) regs[rd]      <= rd_data;
   end

   // Set is applied after clear so a same-cycle set on the written register wins
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         if (wr_en)  busy[rd]    <= 1'b0;
         if (set_en) busy[sb_rd] <= 1'b1;
      end
   end

   always_comb begin : p_read
      logic [AW-1:0] addr;
      logic          hit_wr;
      logic          hit_set;
      data    = '0;
      rs_busy = '0;
      addr    = '0;
      hit_wr  = 1'b0;
      hit_set = 1'b0;
      for (int unsigned i = 0; i < NRD; i++) begin
         addr    = rs[i*AW +: AW];
         hit_wr  = wr_en && (rd == addr);
         hit_set = set_en && (sb_rd == addr);
         if (ready && (addr != '0)) begin
            if ((BYPASS != 0) && hit_wr) data[i*XLEN +: XLEN] = rd_data;
            else                         data[i*XLEN +: XLEN] = regs[addr];
            rs_busy[i] = busy[addr] && !((BYPASS != 0) && hit_wr && !hit_set);
         end
      end
   end

endmodule
